// File: rtl/parallel_to_serial_pkg.sv
// parallel_to_serial_pkg: shared state encoding and sizing helper for the parallel-to-serial transmitter.
package parallel_to_serial_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} p2s_state_t;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/parallel_to_serial_if.sv
// parallel_to_serial_if: parallel-in and serial-out valid/ready channels of the transmitter.
interface parallel_to_serial_if #(parameter int width = 8);
  logic parallel_valid;
  logic [width-1:0] parallel_data;
  logic parallel_ready;
  logic serial_valid;
  logic serial_data;
  logic serial_ready;
  logic serial_last;
  modport master(output parallel_valid, parallel_data, serial_ready, input parallel_ready, serial_valid, serial_data, serial_last);
  modport slave(input parallel_valid, parallel_data, serial_ready, output parallel_ready, serial_valid, serial_data, serial_last);
endinterface

// File: rtl/p2s_shift_reg.sv
// p2s_shift_reg: loadable right shifter emitting bit 0; with PARALLEL_TO_SERIAL_PARITY_EN it also
// accumulates the XOR of the shifted-out bits and presents it when sel_par is high.
module p2s_shift_reg #(parameter int width = 8) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  input  logic [width-1:0] din,
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
  input  logic sel_par,
`endif
  output logic dout
);
  logic [width-1:0] q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (load) q <= din;
    else if (shift) q <= {1'b0, q[width-1:1]};
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
  logic par;
  always_ff @(posedge clk or posedge rst)
    if (rst) par <= 1'b0;
    else if (load) par <= 1'b0;
    else if (shift) par <= par ^ q[0];
  assign dout = sel_par ? par : q[0];
`else
  assign dout = q[0];
`endif
endmodule

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: LSB-first word serializer with a one-word holding register for gap-free streaming.
// Optional trailing even-parity bit when PARALLEL_TO_SERIAL_PARITY_EN is defined.
module parallel_to_serial import parallel_to_serial_pkg::*; #(parameter int width = 8) (
  input  logic clk,
  input  logic rst,
  parallel_to_serial_if.slave bus,
  output logic busy
);
  localparam int cw = cnt_width(width);
  p2s_state_t state;
  logic [cw-1:0] cnt;
  logic hold_full;
  logic [width-1:0] hold_data;
  logic accept, xfer, eof, load, shift, last_bit;
  assign bus.parallel_ready = !rst && !hold_full;
  assign accept = bus.parallel_valid && bus.parallel_ready;
  assign xfer = bus.serial_valid && bus.serial_ready;
  assign last_bit = cnt == cw'(width - 1);
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
  assign eof = xfer && state == PARITY;
`else
  assign eof = xfer && state == SHIFT && last_bit;
`endif
  // a held word wins over a fresh one at end of frame; ready is low whenever hold is full anyway
  assign load = (accept && state == IDLE) || (eof && (hold_full || accept));
  assign shift = xfer && state == SHIFT;
  assign busy = state != IDLE || hold_full;
  p2s_shift_reg #(.width(width)) u_shift (
    .clk(clk),
    .rst(rst),
    .load(load),
    .shift(shift),
    .din(hold_full ? hold_data : bus.parallel_data),
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
    .sel_par(state == PARITY),
`endif
    .dout(bus.serial_data)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      bus.serial_valid <= 1'b0;
      bus.serial_last <= 1'b0;
    end else begin
      if (accept && state != IDLE && !eof) begin
        hold_full <= 1'b1;
        hold_data <= bus.parallel_data;
      end else if (load) hold_full <= 1'b0;
      if (load) begin
        state <= SHIFT;
        cnt <= '0;
        bus.serial_valid <= 1'b1;
        bus.serial_last <= 1'b0;
      end else if (eof) begin
        state <= IDLE;
        cnt <= '0;
        bus.serial_valid <= 1'b0;
        bus.serial_last <= 1'b0;
      end else if (shift) begin
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
        if (last_bit) begin
          state <= PARITY;
          cnt <= cw'(width);
          bus.serial_last <= 1'b1;
        end else cnt <= cnt + cw'(1);
`else
        cnt <= cnt + cw'(1);
        bus.serial_last <= cnt == cw'(width - 2);
`endif
      end
    end
endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial: randomized checks of the serializer against a word-to-bitstream reference model.
module tb_parallel_to_serial;
  localparam int W = 8;
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif
  typedef struct packed {logic d; logic l;} sbit_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  parallel_to_serial_if #(.width(W)) bus();
  parallel_to_serial #(.width(W)) dut(.clk(clk), .rst(rst), .bus(bus), .busy(busy));
  always #5 clk = ~clk;
  int compared = 0, mismatched = 0;
  sbit_t obs[$], exp_q[$];
  logic [W-1:0] acc[$];
  bit vtrace[$];
  int stall_viol, blocked;
  bit prev_stall, saw_not_ready;
  sbit_t prev_b;

  function automatic void clear();
    obs = {}; exp_q = {}; acc = {}; vtrace = {};
    stall_viol = 0; blocked = 0; prev_stall = 0; saw_not_ready = 0;
  endfunction

  // every accepted word becomes its bits LSB first, optional even parity, last flag on the final bit
  function automatic void build_exp();
    exp_q = {};
    foreach (acc[k]) begin
      for (int i = 0; i < W; i++) exp_q.push_back('{d: acc[k][i], l: (i == FL - 1)});
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
      exp_q.push_back('{d: ^acc[k], l: 1'b1});
`endif
    end
  endfunction

  task automatic tick();
    sbit_t b;
    b = '{d: bus.serial_data, l: bus.serial_last};
    if (prev_stall && (!bus.serial_valid || b !== prev_b)) stall_viol++;
    prev_stall = bus.serial_valid && !bus.serial_ready;
    prev_b = b;
    if (!bus.parallel_ready && !rst) saw_not_ready = 1;
    if (bus.parallel_valid && bus.parallel_ready) acc.push_back(bus.parallel_data);
    if (bus.serial_valid && bus.serial_ready) obs.push_back(b);
    vtrace.push_back(bus.serial_valid);
    @(posedge clk);
    @(negedge clk);
  endtask

  // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready and random offer gaps
  task automatic run(input logic [W-1:0] words[$], input int mode, output bit to);
    int idx;
    bit offer;
    idx = 0; offer = 0; to = 1;
    for (int c = 0; c < 3000; c++) begin
      if (idx < words.size() && !offer) offer = mode != 2 || $urandom_range(0, 3) != 0;
      bus.parallel_valid = offer;
      bus.parallel_data = offer ? words[idx] : W'($urandom);
      bus.serial_ready = mode == 0 ? 1'b1 : mode == 1 ? (c % 3 == 0) : ($urandom_range(0, 2) != 0);
      if (offer && !bus.parallel_ready) blocked++;
      if (offer && bus.parallel_ready) begin idx++; offer = 0; end
      tick();
      if (idx == words.size() && !offer && !busy && !bus.serial_valid) begin to = 0; break; end
    end
    bus.parallel_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.parallel_valid = 1'b0; bus.parallel_data = '0; bus.serial_ready = 1'b0;
    @(negedge clk);
    compared++; if (bus.serial_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", bus.serial_valid); end
    compared++; if (bus.serial_data !== 1'b0) begin mismatched++; $display("FAIL reset_data: got %b want 0", bus.serial_data); end
    compared++; if (bus.serial_last !== 1'b0) begin mismatched++; $display("FAIL reset_last: got %b want 0", bus.serial_last); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if (bus.parallel_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready: got %b want 0", bus.parallel_ready); end
    rst = 1'b0;
    #1;
    compared++; if (bus.parallel_ready !== 1'b1) begin mismatched++; $display("FAIL release_ready: got %b want 1", bus.parallel_ready); end
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [W-1:0] w[$];
    bit to;
    int first, last, ones;
    clear();
    bus.parallel_valid = 1'b1; bus.parallel_data = 8'hA5; bus.serial_ready = 1'b1;
    tick();
    bus.parallel_valid = 1'b0;
    compared++; if (bus.serial_valid !== 1'b1 || bus.serial_data !== 1'b1) begin mismatched++; $display("FAIL single_latency: got v%b d%b want v1 d1", bus.serial_valid, bus.serial_data); end
    w = {};
    run(w, 0, to);
    compared++; if (to) begin mismatched++; $display("FAIL single_timeout: got timeout want idle"); end
    build_exp();
    compared++; if (obs.size() != FL) begin mismatched++; $display("FAIL single_len: got %0d want %0d", obs.size(), FL); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      compared++; if (obs[i] !== exp_q[i]) begin mismatched++; $display("FAIL single_bit%0d: got d%b l%b want d%b l%b", i, obs[i].d, obs[i].l, exp_q[i].d, exp_q[i].l); end
    end
    first = -1; last = -1; ones = 0;
    foreach (vtrace[i]) if (vtrace[i]) begin if (first < 0) first = i; last = i; ones++; end
    compared++; if (ones != FL || last - first + 1 != ones) begin mismatched++; $display("FAIL single_valid_run: got %0d over %0d cycles want %0d contiguous", ones, last - first + 1, FL); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL single_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w[$];
    bit to;
    int first, last, ones;
    clear();
    w = {8'hA5, 8'h3C};
    run(w, 0, to);
    compared++; if (to) begin mismatched++; $display("FAIL b2b_timeout: got timeout want idle"); end
    compared++; if (!saw_not_ready) begin mismatched++; $display("FAIL b2b_ready_low: got never low want low while held"); end
    build_exp();
    compared++; if (obs.size() != 2 * FL) begin mismatched++; $display("FAIL b2b_len: got %0d want %0d", obs.size(), 2 * FL); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      compared++; if (obs[i] !== exp_q[i]) begin mismatched++; $display("FAIL b2b_bit%0d: got d%b l%b want d%b l%b", i, obs[i].d, obs[i].l, exp_q[i].d, exp_q[i].l); end
    end
    first = -1; last = -1; ones = 0;
    foreach (vtrace[i]) if (vtrace[i]) begin if (first < 0) first = i; last = i; ones++; end
    compared++; if (ones != 2 * FL || last - first + 1 != ones) begin mismatched++; $display("FAIL b2b_gap: got %0d over %0d cycles want %0d contiguous", ones, last - first + 1, 2 * FL); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w[$];
    bit to;
    clear();
    w = {8'hF0};
    run(w, 1, to);
    compared++; if (to) begin mismatched++; $display("FAIL bp_timeout: got timeout want idle"); end
    compared++; if (stall_viol != 0) begin mismatched++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_viol); end
    build_exp();
    compared++; if (obs.size() != FL) begin mismatched++; $display("FAIL bp_len: got %0d want %0d", obs.size(), FL); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      compared++; if (obs[i] !== exp_q[i]) begin mismatched++; $display("FAIL bp_bit%0d: got d%b l%b want d%b l%b", i, obs[i].d, obs[i].l, exp_q[i].d, exp_q[i].l); end
    end
  endtask

  task automatic test_third_word();
    logic [W-1:0] w[$];
    bit to;
    clear();
    w = {W'($urandom), W'($urandom), W'($urandom)};
    run(w, 0, to);
    compared++; if (to) begin mismatched++; $display("FAIL third_timeout: got timeout want idle"); end
    compared++; if (blocked == 0) begin mismatched++; $display("FAIL third_blocked: got ready high want low while held"); end
    compared++; if (acc.size() != 3) begin mismatched++; $display("FAIL third_accepts: got %0d want 3", acc.size()); end
    for (int i = 0; i < 3 && i < acc.size(); i++) begin
      compared++; if (acc[i] !== w[i]) begin mismatched++; $display("FAIL third_word%0d: got %h want %h", i, acc[i], w[i]); end
    end
    build_exp();
    compared++; if (obs.size() != 3 * FL) begin mismatched++; $display("FAIL third_len: got %0d want %0d", obs.size(), 3 * FL); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      compared++; if (obs[i] !== exp_q[i]) begin mismatched++; $display("FAIL third_bit%0d: got d%b l%b want d%b l%b", i, obs[i].d, obs[i].l, exp_q[i].d, exp_q[i].l); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] w[$];
    bit to;
    for (int r = 0; r < 8; r++) begin
      clear();
      w = {};
      for (int k = 0; k < $urandom_range(1, 4); k++) w.push_back(W'($urandom));
      run(w, 2, to);
      compared++; if (to) begin mismatched++; $display("FAIL rand%0d_timeout: got timeout want idle", r); end
      compared++; if (stall_viol != 0) begin mismatched++; $display("FAIL rand%0d_stable: got %0d want 0", r, stall_viol); end
      build_exp();
      compared++; if (obs.size() != w.size() * FL) begin mismatched++; $display("FAIL rand%0d_len: got %0d want %0d", r, obs.size(), w.size() * FL); end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
        compared++; if (obs[i] !== exp_q[i]) begin mismatched++; $display("FAIL rand%0d_bit%0d: got d%b l%b want d%b l%b", r, i, obs[i].d, obs[i].l, exp_q[i].d, exp_q[i].l); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w[$];
    bit to;
    clear();
    bus.parallel_valid = 1'b1; bus.parallel_data = 8'hFF; bus.serial_ready = 1'b1;
    for (int c = 0; c < 20 && obs.size() < 3; c++) begin
      tick();
      bus.parallel_valid = 1'b0;
    end
    compared++; if (obs.size() != 3) begin mismatched++; $display("FAIL mid_prefix: got %0d bits want 3", obs.size()); end
    #2 rst = 1'b1;
    #1;
    compared++; if ({bus.serial_valid, bus.serial_data, bus.serial_last, busy} !== 4'b0) begin mismatched++; $display("FAIL mid_outputs: got v%b d%b l%b b%b want all 0", bus.serial_valid, bus.serial_data, bus.serial_last, busy); end
    compared++; if (bus.parallel_ready !== 1'b0) begin mismatched++; $display("FAIL mid_ready: got %b want 0", bus.parallel_ready); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear();
    for (int c = 0; c < 5; c++) tick();
    compared++; if (obs.size() != 0) begin mismatched++; $display("FAIL mid_stale: got %0d bits want 0", obs.size()); end
    w = {8'h01};
    run(w, 0, to);
    build_exp();
    compared++; if (to || obs.size() != FL) begin mismatched++; $display("FAIL mid_next_len: got %0d want %0d", obs.size(), FL); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      compared++; if (obs[i] !== exp_q[i]) begin mismatched++; $display("FAIL mid_next_bit%0d: got d%b l%b want d%b l%b", i, obs[i].d, obs[i].l, exp_q[i].d, exp_q[i].l); end
    end
  endtask

`ifdef PARALLEL_TO_SERIAL_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] w[$];
    bit to;
    clear();
    w = {8'hA5, 8'h07};
    run(w, 0, to);
    compared++; if (to || obs.size() != 18) begin mismatched++; $display("FAIL par_len: got %0d want 18", obs.size()); end
    if (obs.size() >= 18) begin
      compared++; if (obs[8] !== 2'b01) begin mismatched++; $display("FAIL par_a5: got d%b l%b want d0 l1", obs[8].d, obs[8].l); end
      compared++; if (obs[17] !== 2'b11) begin mismatched++; $display("FAIL par_07: got d%b l%b want d1 l1", obs[17].d, obs[17].l); end
      compared++; if (obs[7].l !== 1'b0) begin mismatched++; $display("FAIL par_bit7_last: got %b want 0", obs[7].l); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_third_word();
    test_random();
    test_reset_mid();
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
- Converts a `width`-bit parallel word into a one-bit serial stream, LSB first.
- It is the transmit-side counterpart of the serial-to-parallel receiver already in the sequential-basics set.
- The parallel side uses a valid/ready handshake. The serial side uses a valid/ready handshake with backpressure.
- A one-word holding register lets back-to-back words stream with no gap cycle on the serial side.

Parameters:
- width, 8, number of data bits per word. Must be ≥ 2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- parallel_valid  input  1  a word is offered on parallel_data.
- parallel_data  input  width  word to serialize. Bit 0 is sent first.
- parallel_ready  output  1  block can accept a word this cycle.
- serial_valid  output  1  serial_data holds a valid bit.
- serial_data  output  1  current serial bit.
- serial_ready  input  1  downstream consumes the bit when serial_valid is also high.
- serial_last  output  1  marks the final bit of the current frame.
- busy  output  1  a frame is in progress or a word is held.

Behaviour:
- Reset:
  - rst is asynchronous and active-high.
  - It clears state to IDLE, the shift register, the bit counter, hold_full, serial_valid, serial_data, serial_last and busy.
  - parallel_ready is 0 while rst is high.
- Accept: a word is accepted on an edge where parallel_valid && parallel_ready.
  - parallel_ready = !rst && !hold_full (combinational).
- Serial handshake: a bit transfers on an edge where serial_valid && serial_ready.
  - While serial_valid && !serial_ready, serial_data and serial_last must hold stable.
- FSM states: IDLE and SHIFT (plus PARITY when the optional feature is compiled in).
  - IDLE:
    - On accept, load the word directly into the shifter, set bit count = 0 and go to SHIFT.
    - Latency is 1: serial_valid rises the cycle after the accept, carrying bit 0.
  - SHIFT:
    - serial_valid = 1 and serial_data = shifter[0].
    - On each serial handshake, shift right and increment the count.
    - Accepts during SHIFT go to the holding register (hold_full <= 1).
  - End of frame: the last data-bit handshake (count == width-1) is the end of frame when the feature is off.
    - If hold_full: load the held word into the shifter and clear hold_full. The next frame's bit 0 appears the very next cycle, with no bubble.
    - Else, if an accept occurs that same edge: load the accepted word directly into the shifter.
    - Else: go to IDLE; serial_valid is 0 on the next cycle.
- serial_last is 1 exactly when the current bit is the frame's final bit.
- busy = (state != IDLE) || hold_full.
- The bit counter is $clog2(width+1) bits wide and never wraps past width.
- Reset asserted mid-frame: the frame is aborted immediately. No partial bits are emitted after rst deasserts, and any held word is discarded.

Optional Feature:
- Macro: PARALLEL_TO_SERIAL_PARITY_EN.
- Defined:
  - After the width-th data bit handshakes, the FSM enters PARITY.
  - It emits one extra bit equal to the XOR of the frame's data word (even parity); this bit carries serial_last = 1.
  - The end-of-frame rules above then apply at the parity-bit handshake.
  - A frame is width+1 serial bits.
- Undefined:
  - The PARITY state, the parity register and the parity logic are absent.
  - The frame is width bits, and serial_last marks bit width-1.

Decomposition:
- Package parallel_to_serial_pkg:
  - State enum p2s_state_t {IDLE, SHIFT, PARITY}.
  - Function for the counter width.
- Sub-module p2s_shift_reg:
  - Parallel load, right shift on enable, output bit 0.
  - Also holds the parity accumulator when the feature is enabled.
- The top level owns the FSM, counter, holding register and handshakes.

Test Plan:
- Single word, width=8, serial_ready held 1: accept 8'hA5.
  - Starting one cycle later, 8 consecutive serial_valid cycles carry bits 1,0,1,0,0,1,0,1.
  - serial_last is high on the 8th bit only; busy drops after it.
- Back-to-back, serial_ready held 1: offer 8'hA5 then 8'h3C continuously.
  - Result is 16 consecutive serial_valid cycles with no gap; second frame bits are 0,0,1,1,1,1,0,0.
  - parallel_ready goes low while hold is full.
- Backpressure: send 8'hF0 with serial_ready toggling 1,0,0,1,...
  - serial_data and serial_last stay stable during stalls.
  - The output stream is still 0,0,0,0,1,1,1,1.
- Third word while busy: with a frame shifting and hold full, parallel_ready is 0.
  - A word offered then is not accepted until the current frame finishes; no word is lost or duplicated.
- Reset mid-frame: assert rst asynchronously after bit 3 of 8'hFF.
  - All outputs go to 0 immediately and parallel_ready is 0.
  - After release, no stale bits appear; the next word 8'h01 serializes correctly.
- With PARALLEL_TO_SERIAL_PARITY_EN defined:
  - 8'hA5 is followed by parity bit 0, and 8'h07 by parity bit 1.
  - Frames are 9 bits, and serial_last is on the parity bit.
